// File: rtl/nm_pkg.sv
// Shared constants and types for the note matcher.
// Lane index, event kinds and sizing live here.
package nm_pkg;
  localparam int LANES  = 5;
  localparam int DEPTH  = 4;
  localparam int TW     = 16;
  localparam int WINDOW = 100;

  typedef logic [2:0] lane_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_MATCH,
    EV_MISS,
    EV_GHOST
  } ev_e;
endpackage

// File: rtl/nm_lane_fifo.sv
// Per-lane pending-note FIFO, DEPTH x TW.
// Pop when empty and push when full are ignored.
module nm_lane_fifo
  import nm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [TW-1:0] din,
  output logic [TW-1:0] head,
  output logic          empty,
  output logic          full
);
  localparam int PW = $clog2(DEPTH);

  logic [TW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end
endmodule

// File: rtl/note_matcher.sv
// Judges button presses against queued chart notes.
// One lane is scanned per cycle; events are registered.
module note_matcher
  import nm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             note_valid,
  input  lane_t            note_lane,
  input  logic [TW-1:0]    note_time,
  output logic             note_ready,
  input  logic [LANES-1:0] btn,
  output logic [TW-1:0]    now,
  output logic             match_en,
  output logic [TW-1:0]    dt,
  output lane_t            match_lane,
  output logic             miss,
  output lane_t            miss_lane,
  output logic             ghost
);
  localparam logic signed [TW-1:0] WIN = TW'(WINDOW);

  logic [TW-1:0]        now_q;
  logic [TW-1:0]        dt_q;
  lane_t                lane_q;
  lane_t                mlane_q;
  lane_t                xlane_q;
  logic                 match_q;
  logic                 miss_q;
  logic                 ghost_q;
  logic [LANES-1:0]     btn_q;
  logic [LANES-1:0]     pend_q;
  logic [LANES-1:0]     pend_d;
  logic [LANES-1:0]     push;
  logic [LANES-1:0]     pop;
  logic [LANES-1:0]     clr;
  logic [LANES-1:0]     empty;
  logic [LANES-1:0]     full;
  logic [TW-1:0]        head [LANES];
  logic [TW-1:0]        head_s;
  logic                 empty_s;
  logic                 pend_s;
  logic signed [TW-1:0] diff;
  logic [TW-1:0]        mag;
  ev_e                  ev;

  always_comb begin
    note_ready = 1'b0;
    push       = '0;
    for (int i = 0; i < LANES; i++) begin
      if (note_lane == lane_t'(i)) begin
        note_ready = ~full[i];
        push[i]    = note_valid & ~full[i];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    nm_lane_fifo u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (note_time),
      .head  (head[g]),
      .empty (empty[g]),
      .full  (full[g])
    );
  end

  // Modular difference keeps notes across the time rollover judgeable.
  always_comb begin
    head_s  = '0;
    empty_s = 1'b1;
    pend_s  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == lane_t'(i)) begin
        head_s  = head[i];
        empty_s = empty[i];
        pend_s  = pend_q[i];
      end
    end
    diff = $signed(now_q - head_s);
    mag  = diff[TW-1] ? $unsigned(-diff) : $unsigned(diff);
    ev   = EV_NONE;
    if (!empty_s && diff >= WIN) begin
      ev = EV_MISS;
    end else if (pend_s && !empty_s && diff > -WIN) begin
      ev = EV_MATCH;
    end else if (pend_s) begin
      ev = EV_GHOST;
    end
    pop = '0;
    clr = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == lane_t'(i)) begin
        pop[i] = (ev == EV_MATCH) || (ev == EV_MISS);
        clr[i] = (ev == EV_MATCH) || (ev == EV_GHOST);
      end
    end
    pend_d = (pend_q & ~clr) | (btn & ~btn_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now_q   <= '0;
      lane_q  <= '0;
      btn_q   <= '0;
      pend_q  <= '0;
      match_q <= 1'b0;
      miss_q  <= 1'b0;
      ghost_q <= 1'b0;
      dt_q    <= '0;
      mlane_q <= '0;
      xlane_q <= '0;
    end else begin
      if (tick) begin
        now_q <= now_q + 1'b1;
      end
      lane_q  <= (lane_q == lane_t'(LANES-1)) ? '0 : lane_q + 1'b1;
      btn_q   <= btn;
      pend_q  <= pend_d;
      match_q <= (ev == EV_MATCH);
      miss_q  <= (ev == EV_MISS);
      ghost_q <= (ev == EV_GHOST);
      dt_q    <= (ev == EV_MATCH) ? mag : '0;
      mlane_q <= (ev == EV_MATCH) ? lane_q : '0;
      xlane_q <= (ev == EV_MISS) ? lane_q : '0;
    end
  end

  assign now        = now_q;
  assign match_en   = match_q;
  assign dt         = dt_q;
  assign match_lane = mlane_q;
  assign miss       = miss_q;
  assign miss_lane  = xlane_q;
  assign ghost      = ghost_q;
endmodule

// File: tb/tb_note_matcher.sv
// Self-checking bench for note_matcher.
// Directed scenarios plus random traffic against a queue model.
module tb_note_matcher;
  import nm_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick = 1'b0;
  logic             note_valid = 1'b0;
  logic [2:0]       note_lane = 3'd0;
  logic [TW-1:0]    note_time = '0;
  logic [LANES-1:0] btn = '0;
  logic             note_ready;
  logic [TW-1:0]    now;
  logic             match_en;
  logic [TW-1:0]    dt;
  logic [2:0]       match_lane;
  logic             miss;
  logic [2:0]       miss_lane;
  logic             ghost;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  note_matcher dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .note_valid (note_valid),
    .note_lane  (note_lane),
    .note_time  (note_time),
    .note_ready (note_ready),
    .btn        (btn),
    .now        (now),
    .match_en   (match_en),
    .dt         (dt),
    .match_lane (match_lane),
    .miss       (miss),
    .miss_lane  (miss_lane),
    .ghost      (ghost)
  );

  // Reference model: per-lane queues, integer song time, round-robin visit
  int               m_now;
  int               m_lane;
  int               m_q [LANES][$];
  bit [LANES-1:0]   m_pend;
  bit [LANES-1:0]   m_bprev;
  bit               e_match;
  bit               e_miss;
  bit               e_ghost;
  int               e_dt;
  int               e_mlane;
  int               e_xlane;
  int               md;
  bit               macc;
  bit               mhas;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_now = 0; m_lane = 0; m_pend = '0; m_bprev = '0;
      e_match = 0; e_miss = 0; e_ghost = 0;
      e_dt = 0; e_mlane = 0; e_xlane = 0;
      foreach (m_q[i]) m_q[i].delete();
    end else begin
      macc = note_valid && (note_lane < LANES) && (m_q[note_lane].size() < DEPTH);
      e_match = 0; e_miss = 0; e_ghost = 0; e_dt = 0;
      mhas = (m_q[m_lane].size() > 0);
      md = 0;
      if (mhas) begin
        md = (m_now - m_q[m_lane][0]) % 65536;
        if (md < 0) md += 65536;
        if (md >= 32768) md -= 65536;
      end
      if (mhas && md >= WINDOW) begin
        e_miss = 1; e_xlane = m_lane;
        void'(m_q[m_lane].pop_front());
      end else if (m_pend[m_lane] && mhas && md > -WINDOW) begin
        e_match = 1; e_mlane = m_lane;
        e_dt = (md < 0) ? -md : md;
        void'(m_q[m_lane].pop_front());
        m_pend[m_lane] = 0;
      end else if (m_pend[m_lane]) begin
        e_ghost = 1;
        m_pend[m_lane] = 0;
      end
      if (macc) m_q[note_lane].push_back(int'(note_time));
      m_pend = m_pend | (btn & ~m_bprev);
      m_bprev = btn;
      if (tick) m_now = (m_now + 1) % 65536;
      m_lane = (m_lane + 1) % LANES;
    end
  end

  task automatic do_reset;
    rst_n = 1'b0; tick = 0; note_valid = 0; note_lane = 0; note_time = '0; btn = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic push(input int l, input int t);
    note_valid = 1'b1; note_lane = 3'(l); note_time = TW'(t);
    @(negedge clk);
    note_valid = 1'b0;
  endtask

  task automatic watch(input int n, output int nm, output int nx, output int ng,
                       output int dv, output int mm, output int xm);
    nm = 0; nx = 0; ng = 0; dv = 0; mm = 0; xm = 0;
    repeat (n) begin
      @(negedge clk);
      btn = '0;
      if (match_en) begin nm++; dv |= int'(dt); mm |= (1 << match_lane); end
      if (miss) begin nx++; xm |= (1 << miss_lane); end
      if (ghost) ng++;
    end
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++; if (now !== '0) begin n_fail++; $display("FAIL rst_now got %0d exp 0", now); end
    n_checks++; if ({match_en, miss, ghost} !== 3'b000) begin n_fail++; $display("FAIL rst_strobes got %b exp 000", {match_en, miss, ghost}); end
    n_checks++; if (dt !== '0 || match_lane !== 3'd0 || miss_lane !== 3'd0) begin n_fail++; $display("FAIL rst_data got dt=%0d ml=%0d xl=%0d exp 0", dt, match_lane, miss_lane); end
    note_lane = 3'd3; #1;
    n_checks++; if (note_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready3 got %b exp 1", note_ready); end
    note_lane = 3'd5; #1;
    n_checks++; if (note_ready !== 1'b0) begin n_fail++; $display("FAIL ready_lane5 got %b exp 0", note_ready); end
    note_lane = 3'd7; #1;
    n_checks++; if (note_ready !== 1'b0) begin n_fail++; $display("FAIL ready_lane7 got %b exp 0", note_ready); end
    note_lane = 3'd0;
  endtask

  task automatic test_match;
    int nm, nx, ng, dv, mm, xm;
    do_reset;
    push(2, 50);
    ticks(45);
    n_checks++; if (now !== 16'd45) begin n_fail++; $display("FAIL m_now got %0d exp 45", now); end
    btn[2] = 1'b1;
    watch(LANES + 2, nm, nx, ng, dv, mm, xm);
    n_checks++; if (nm !== 1 || nx !== 0 || ng !== 0) begin n_fail++; $display("FAIL m_cnt got m=%0d x=%0d g=%0d exp 1/0/0", nm, nx, ng); end
    n_checks++; if (dv !== 5 || mm !== 4) begin n_fail++; $display("FAIL m_dt got dt=%0d mask=%0d exp 5/4", dv, mm); end
    btn[2] = 1'b1;
    watch(LANES + 2, nm, nx, ng, dv, mm, xm);
    n_checks++; if (nm !== 0 || ng !== 1) begin n_fail++; $display("FAIL m_empty got m=%0d g=%0d exp 0/1", nm, ng); end
  endtask

  task automatic test_miss;
    int nm, nx, ng, dv, mm, xm;
    int early;
    early = 0;
    do_reset;
    push(0, 10);
    tick = 1'b1;
    repeat (109) begin
      @(negedge clk);
      if (miss) early++;
    end
    tick = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (miss) early++;
    end
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    if (miss) early++;
    n_checks++; if (early !== 0) begin n_fail++; $display("FAIL x_early got %0d exp 0", early); end
    n_checks++; if (now !== 16'd110) begin n_fail++; $display("FAIL x_now got %0d exp 110", now); end
    watch(LANES + 1, nm, nx, ng, dv, mm, xm);
    n_checks++; if (nx !== 1 || xm !== 1 || nm !== 0) begin n_fail++; $display("FAIL x_miss got x=%0d mask=%0d m=%0d exp 1/1/0", nx, xm, nm); end
  endtask

  task automatic test_ghost;
    int nm, nx, ng, dv, mm, xm;
    do_reset;
    btn[3] = 1'b1;
    watch(LANES + 2, nm, nx, ng, dv, mm, xm);
    n_checks++; if (ng !== 1 || nm !== 0) begin n_fail++; $display("FAIL g_empty got g=%0d m=%0d exp 1/0", ng, nm); end
    push(3, 500);
    btn[3] = 1'b1;
    watch(LANES + 2, nm, nx, ng, dv, mm, xm);
    n_checks++; if (ng !== 1 || nm !== 0) begin n_fail++; $display("FAIL g_early got g=%0d m=%0d exp 1/0", ng, nm); end
    ticks(450);
    btn[3] = 1'b1;
    watch(LANES + 2, nm, nx, ng, dv, mm, xm);
    n_checks++; if (nm !== 1 || dv !== 50 || ng !== 0) begin n_fail++; $display("FAIL g_kept got m=%0d dt=%0d g=%0d exp 1/50/0", nm, dv, ng); end
  endtask

  task automatic test_full;
    int nm, nx, ng, dv, mm, xm;
    int pushed;
    int exp_dt[4];
    exp_dt = '{20, 30, 40, 50};
    do_reset;
    push(1, 100); push(1, 110); push(1, 120); push(1, 130);
    note_valid = 1'b1; note_lane = 3'd1; note_time = 16'd999; #1;
    n_checks++; if (note_ready !== 1'b0) begin n_fail++; $display("FAIL f_full got %b exp 0", note_ready); end
    @(negedge clk);
    note_valid = 1'b0;
    ticks(100);
    btn[1] = 1'b1;
    watch(LANES + 2, nm, nx, ng, dv, mm, xm);
    n_checks++; if (nm !== 1 || dv !== 0) begin n_fail++; $display("FAIL f_first got m=%0d dt=%0d exp 1/0", nm, dv); end
    btn[1] = 1'b1; pushed = 0; nm = 0; dv = 0;
    repeat (LANES + 2) begin
      @(negedge clk);
      btn = '0; note_valid = 1'b0;
      if (match_en) begin nm++; dv = int'(dt); end
      if (pushed == 0 && m_lane == 1 && m_pend[1]) begin
        note_valid = 1'b1; note_lane = 3'd1; note_time = 16'd140; pushed = 1;
      end
    end
    note_valid = 1'b0;
    n_checks++; if (pushed !== 1 || nm !== 1 || dv !== 10) begin n_fail++; $display("FAIL f_simul got p=%0d m=%0d dt=%0d exp 1/1/10", pushed, nm, dv); end
    note_lane = 3'd1; #1;
    n_checks++; if (note_ready !== 1'b1) begin n_fail++; $display("FAIL f_cnt3 got %b exp 1", note_ready); end
    push(1, 150);
    note_lane = 3'd1; #1;
    n_checks++; if (note_ready !== 1'b0) begin n_fail++; $display("FAIL f_cnt4 got %b exp 0", note_ready); end
    for (int k = 0; k < 4; k++) begin
      btn[1] = 1'b1;
      watch(LANES + 2, nm, nx, ng, dv, mm, xm);
      n_checks++; if (nm !== 1 || dv !== exp_dt[k]) begin n_fail++; $display("FAIL f_order%0d got m=%0d dt=%0d exp 1/%0d", k, nm, dv, exp_dt[k]); end
    end
    btn[1] = 1'b1;
    watch(LANES + 2, nm, nx, ng, dv, mm, xm);
    n_checks++; if (ng !== 1 || nm !== 0) begin n_fail++; $display("FAIL f_drain got g=%0d m=%0d exp 1/0", ng, nm); end
  endtask

  task automatic test_wrap;
    int nm, nx, ng, dv, mm, xm;
    do_reset;
    ticks(65530);
    n_checks++; if (now !== 16'd65530) begin n_fail++; $display("FAIL w_now got %0d exp 65530", now); end
    push(1, 3);
    push(2, 3);
    ticks(4);
    btn[1] = 1'b1;
    watch(LANES + 2, nm, nx, ng, dv, mm, xm);
    n_checks++; if (nm !== 1 || dv !== 5 || mm !== 2 || nx !== 0) begin n_fail++; $display("FAIL w_pre got m=%0d dt=%0d mask=%0d x=%0d exp 1/5/2/0", nm, dv, mm, nx); end
    ticks(4);
    n_checks++; if (now !== 16'd2) begin n_fail++; $display("FAIL w_roll got %0d exp 2", now); end
    btn[2] = 1'b1;
    watch(LANES + 2, nm, nx, ng, dv, mm, xm);
    n_checks++; if (nm !== 1 || dv !== 1 || mm !== 4 || nx !== 0) begin n_fail++; $display("FAIL w_post got m=%0d dt=%0d mask=%0d x=%0d exp 1/1/4/0", nm, dv, mm, nx); end
  endtask

  task automatic test_back_to_back;
    int nm, nx, ng, dv, mm, xm;
    do_reset;
    ticks(20);
    push(0, 20);
    push(4, 20);
    btn = 5'b10001;
    watch(LANES + 2, nm, nx, ng, dv, mm, xm);
    n_checks++; if (nm !== 2 || dv !== 0 || mm !== 17) begin n_fail++; $display("FAIL b_two got m=%0d dt=%0d mask=%0d exp 2/0/17", nm, dv, mm); end
    push(2, 30);
    rst_n = 1'b0; #1;
    n_checks++; if ({match_en, miss, ghost} !== 3'b000 || dt !== '0 || now !== '0) begin n_fail++; $display("FAIL b_rst got s=%b dt=%0d now=%0d exp 000/0/0", {match_en, miss, ghost}, dt, now); end
    @(negedge clk);
    rst_n = 1'b1;
    btn[2] = 1'b1;
    watch(LANES + 2, nm, nx, ng, dv, mm, xm);
    n_checks++; if (ng !== 1 || nm !== 0 || nx !== 0) begin n_fail++; $display("FAIL b_flush got g=%0d m=%0d x=%0d exp 1/0/0", ng, nm, nx); end
  endtask

  task automatic test_random;
    int last[8];
    int nl;
    int t;
    bit exp_ready;
    do_reset;
    foreach (last[i]) last[i] = 0;
    repeat (1500) begin
      n_checks++; if ({match_en, miss, ghost} !== {e_match, e_miss, e_ghost}) begin n_fail++; $display("FAIL r_ev got %b exp %b", {match_en, miss, ghost}, {e_match, e_miss, e_ghost}); end
      n_checks++; if (dt !== TW'(e_dt)) begin n_fail++; $display("FAIL r_dt got %0d exp %0d", dt, e_dt); end
      if (e_match) begin
        n_checks++; if (match_lane !== 3'(e_mlane)) begin n_fail++; $display("FAIL r_mlane got %0d exp %0d", match_lane, e_mlane); end
      end
      if (e_miss) begin
        n_checks++; if (miss_lane !== 3'(e_xlane)) begin n_fail++; $display("FAIL r_xlane got %0d exp %0d", miss_lane, e_xlane); end
      end
      n_checks++; if (now !== TW'(m_now)) begin n_fail++; $display("FAIL r_now got %0d exp %0d", now, m_now); end
      tick = ($urandom_range(0, 1) == 1);
      nl = $urandom_range(0, 7);
      t = m_now + $urandom_range(0, 150);
      if (t > last[nl]) last[nl] = t;
      note_valid = ($urandom_range(0, 2) == 0);
      note_lane = 3'(nl);
      note_time = TW'(last[nl]);
      if ($urandom_range(0, 3) == 0) btn = LANES'($urandom);
      #1;
      exp_ready = (nl < LANES) && (m_q[nl].size() < DEPTH);
      n_checks++; if (note_ready !== exp_ready) begin n_fail++; $display("FAIL r_ready lane %0d got %b exp %b", nl, note_ready, exp_ready); end
      @(negedge clk);
    end
    tick = 1'b0; note_valid = 1'b0; btn = '0;
  endtask

  initial begin
    test_reset;
    test_match;
    test_miss;
    test_ghost;
    test_full;
    test_back_to_back;
    test_random;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
